// File: rtl/tpu_control_unit.sv
// Command sequencer for the weight-stationary TPU tile: decodes one GEMM command and
// strobes the B/A/C buffer reads and D writeback addresses for tpu_core.
module tpu_control_unit #(
  parameter int unsigned ADDR_WIDTH           = 10,
  parameter int unsigned SYSTOLIC_ARRAY_WIDTH = 16,
  parameter int unsigned C_DELAY              = 2 * SYSTOLIC_ARRAY_WIDTH
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    cmd_valid,
  input  logic [63:0]                             cmd_data,
  output logic                                    cmd_ready,
  output logic                                    busy,
  output logic                                    done_irq,
  output logic [ADDR_WIDTH-1:0]                   ctrl_rd_addr_a,
  output logic                                    ctrl_rd_en_a,
  output logic                                    ctrl_a_valid,
  output logic                                    ctrl_a_switch,
  output logic                                    ctrl_psum_valid,
  output logic [ADDR_WIDTH-1:0]                   ctrl_rd_addr_b,
  output logic                                    ctrl_rd_en_b,
  output logic                                    ctrl_b_accept_w,
  output logic [$clog2(SYSTOLIC_ARRAY_WIDTH)-1:0] ctrl_b_weight_index,
  output logic [ADDR_WIDTH-1:0]                   ctrl_rd_addr_c,
  output logic                                    ctrl_rd_en_c,
  output logic                                    ctrl_c_valid,
  output logic [2:0]                              ctrl_vpu_mode,
  input  logic                                    core_writeback_valid,
  output logic [ADDR_WIDTH-1:0]                   ctrl_wr_addr_d,
  output logic [SYSTOLIC_ARRAY_WIDTH-1:0]         ctrl_row_mask,
  output logic [SYSTOLIC_ARRAY_WIDTH-1:0]         ctrl_col_mask
);

  localparam int unsigned AW = ADDR_WIDTH;
  localparam int unsigned W  = SYSTOLIC_ARRAY_WIDTH;
  localparam int unsigned IW = $clog2(W);
  localparam int unsigned BW = $clog2(W + 1);
  localparam int unsigned SW = $clog2(256 + C_DELAY);

  typedef enum logic [1:0] {IDLE, LOAD_B, STREAM, WAIT_WB} state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   b_cnt_q, b_cnt_d;
  logic [SW-1:0]   s_cnt_q, s_cnt_d;
  logic [7:0]      wb_cnt_q, wb_cnt_d;
  logic [7:0]      len_m_q, len_m_d;
  logic [AW-1:0]   addr_a_q, addr_a_d, addr_b_q, addr_b_d;
  logic [AW-1:0]   addr_c_q, addr_c_d, addr_d_q, addr_d_d;
  logic [W-1:0]    row_mask_q, row_mask_d, col_mask_q, col_mask_d;
  logic            busy_q, busy_d, done_q, done_d;
  logic [2:0]      vpu_mode_q, vpu_mode_d;
  logic            rd_en_a_q, rd_en_a_d, a_valid_q, a_valid_d;
  logic            a_switch_q, a_switch_d, psum_valid_q, psum_valid_d;
  logic [AW-1:0]   rd_addr_a_q, rd_addr_a_d, rd_addr_b_q, rd_addr_b_d;
  logic [AW-1:0]   rd_addr_c_q, rd_addr_c_d;
  logic            rd_en_b_q, rd_en_b_d, accept_w_q, accept_w_d;
  logic [IW-1:0]   rd_idx_b_q, rd_idx_b_d, widx_q, widx_d;
  logic            rd_en_c_q, rd_en_c_d, c_valid_q, c_valid_d;
  logic [SW-1:0]   s_last;

  // Last stream step is the C read of row len_m-1.
  assign s_last = SW'(len_m_q) + SW'(C_DELAY) - SW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      b_cnt_q      <= '0;
      s_cnt_q      <= '0;
      wb_cnt_q     <= '0;
      len_m_q      <= '0;
      addr_a_q     <= '0;
      addr_b_q     <= '0;
      addr_c_q     <= '0;
      addr_d_q     <= '0;
      row_mask_q   <= '0;
      col_mask_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      vpu_mode_q   <= '0;
      rd_en_a_q    <= 1'b0;
      a_valid_q    <= 1'b0;
      a_switch_q   <= 1'b0;
      psum_valid_q <= 1'b0;
      rd_addr_a_q  <= '0;
      rd_addr_b_q  <= '0;
      rd_addr_c_q  <= '0;
      rd_en_b_q    <= 1'b0;
      accept_w_q   <= 1'b0;
      rd_idx_b_q   <= '0;
      widx_q       <= '0;
      rd_en_c_q    <= 1'b0;
      c_valid_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      b_cnt_q      <= b_cnt_d;
      s_cnt_q      <= s_cnt_d;
      wb_cnt_q     <= wb_cnt_d;
      len_m_q      <= len_m_d;
      addr_a_q     <= addr_a_d;
      addr_b_q     <= addr_b_d;
      addr_c_q     <= addr_c_d;
      addr_d_q     <= addr_d_d;
      row_mask_q   <= row_mask_d;
      col_mask_q   <= col_mask_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      vpu_mode_q   <= vpu_mode_d;
      rd_en_a_q    <= rd_en_a_d;
      a_valid_q    <= a_valid_d;
      a_switch_q   <= a_switch_d;
      psum_valid_q <= psum_valid_d;
      rd_addr_a_q  <= rd_addr_a_d;
      rd_addr_b_q  <= rd_addr_b_d;
      rd_addr_c_q  <= rd_addr_c_d;
      rd_en_b_q    <= rd_en_b_d;
      accept_w_q   <= accept_w_d;
      rd_idx_b_q   <= rd_idx_b_d;
      widx_q       <= widx_d;
      rd_en_c_q    <= rd_en_c_d;
      c_valid_q    <= c_valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    b_cnt_d      = b_cnt_q;
    s_cnt_d      = s_cnt_q;
    wb_cnt_d     = wb_cnt_q;
    len_m_d      = len_m_q;
    addr_a_d     = addr_a_q;
    addr_b_d     = addr_b_q;
    addr_c_d     = addr_c_q;
    addr_d_d     = addr_d_q;
    row_mask_d   = row_mask_q;
    col_mask_d   = col_mask_q;
    done_d       = 1'b0;
    rd_en_a_d    = 1'b0;
    rd_en_b_d    = 1'b0;
    rd_en_c_d    = 1'b0;
    rd_addr_a_d  = rd_addr_a_q;
    rd_addr_b_d  = rd_addr_b_q;
    rd_addr_c_d  = rd_addr_c_q;
    rd_idx_b_d   = rd_idx_b_q;
    // Data-side strobes trail their reads by the one-cycle buffer latency.
    accept_w_d   = rd_en_b_q;
    widx_d       = rd_en_b_q ? rd_idx_b_q : widx_q;
    a_valid_d    = rd_en_a_q;
    psum_valid_d = rd_en_a_q;
    a_switch_d   = rd_en_a_q & ~a_valid_q;
    c_valid_d    = rd_en_c_q;

    if (state_q != IDLE && core_writeback_valid) begin
      wb_cnt_d = wb_cnt_q + 8'd1;
    end

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          len_m_d  = cmd_data[7:0];
          addr_a_d = cmd_data[24 +: AW];
          addr_b_d = cmd_data[24 + AW +: AW];
          addr_c_d = cmd_data[24 + 2 * AW +: AW];
          addr_d_d = cmd_data[24 + 3 * AW +: AW];
          for (int i = 0; i < int'(W); i++) begin
            row_mask_d[i] = 8'(i) < cmd_data[15:8];
            col_mask_d[i] = 8'(i) < cmd_data[23:16];
          end
          b_cnt_d  = '0;
          s_cnt_d  = '0;
          wb_cnt_d = '0;
          if (cmd_data[7:0] == 8'd0) begin
            done_d = 1'b1;
          end else begin
            state_d = LOAD_B;
          end
        end
      end
      LOAD_B: begin
        // W reads, then one spare cycle before the A stream starts.
        if (b_cnt_q < BW'(W)) begin
          rd_en_b_d   = 1'b1;
          rd_addr_b_d = addr_b_q + AW'(b_cnt_q);
          rd_idx_b_d  = IW'(b_cnt_q);
          b_cnt_d     = b_cnt_q + BW'(1);
        end else begin
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (s_cnt_q < SW'(len_m_q)) begin
          rd_en_a_d   = 1'b1;
          rd_addr_a_d = addr_a_q + AW'(s_cnt_q);
        end
        if (s_cnt_q >= SW'(C_DELAY)) begin
          rd_en_c_d   = 1'b1;
          rd_addr_c_d = addr_c_q + AW'(s_cnt_q - SW'(C_DELAY));
        end
        if (s_cnt_q == s_last) begin
          state_d = WAIT_WB;
        end else begin
          s_cnt_d = s_cnt_q + SW'(1);
        end
      end
      WAIT_WB: begin
        if ({1'b0, wb_cnt_q} + 9'(core_writeback_valid) >= {1'b0, len_m_q}) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d     = (state_d != IDLE);
    vpu_mode_d = busy_d ? 3'd1 : 3'd0;
  end

  assign cmd_ready           = (state_q == IDLE);
  assign ctrl_wr_addr_d      = addr_d_q + AW'(wb_cnt_q);
  assign busy                = busy_q;
  assign done_irq            = done_q;
  assign ctrl_rd_addr_a      = rd_addr_a_q;
  assign ctrl_rd_en_a        = rd_en_a_q;
  assign ctrl_a_valid        = a_valid_q;
  assign ctrl_a_switch       = a_switch_q;
  assign ctrl_psum_valid     = psum_valid_q;
  assign ctrl_rd_addr_b      = rd_addr_b_q;
  assign ctrl_rd_en_b        = rd_en_b_q;
  assign ctrl_b_accept_w     = accept_w_q;
  assign ctrl_b_weight_index = widx_q;
  assign ctrl_rd_addr_c      = rd_addr_c_q;
  assign ctrl_rd_en_c        = rd_en_c_q;
  assign ctrl_c_valid        = c_valid_q;
  assign ctrl_vpu_mode       = vpu_mode_q;
  assign ctrl_row_mask       = row_mask_q;
  assign ctrl_col_mask       = col_mask_q;

endmodule

// File: tb/tb_tpu_control_unit.sv
// Directed bench for tpu_control_unit: decode, stream timing, writeback, edge commands, mid-run reset.
module tb_tpu_control_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic [63:0] cmd_data;
  logic        cmd_ready, busy, done_irq;
  logic [9:0]  rd_addr_a, rd_addr_b, rd_addr_c, wr_addr_d;
  logic        rd_en_a, a_valid, a_switch, psum_valid;
  logic        rd_en_b, b_accept_w, rd_en_c, c_valid;
  logic [3:0]  b_weight_index;
  logic [2:0]  vpu_mode;
  logic        wb_valid;
  logic [15:0] row_mask, col_mask;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tpu_control_unit dut (
    .clk                 (clk),
    .rst                 (rst),
    .cmd_valid           (cmd_valid),
    .cmd_data            (cmd_data),
    .cmd_ready           (cmd_ready),
    .busy                (busy),
    .done_irq            (done_irq),
    .ctrl_rd_addr_a      (rd_addr_a),
    .ctrl_rd_en_a        (rd_en_a),
    .ctrl_a_valid        (a_valid),
    .ctrl_a_switch       (a_switch),
    .ctrl_psum_valid     (psum_valid),
    .ctrl_rd_addr_b      (rd_addr_b),
    .ctrl_rd_en_b        (rd_en_b),
    .ctrl_b_accept_w     (b_accept_w),
    .ctrl_b_weight_index (b_weight_index),
    .ctrl_rd_addr_c      (rd_addr_c),
    .ctrl_rd_en_c        (rd_en_c),
    .ctrl_c_valid        (c_valid),
    .ctrl_vpu_mode       (vpu_mode),
    .core_writeback_valid(wb_valid),
    .ctrl_wr_addr_d      (wr_addr_d),
    .ctrl_row_mask       (row_mask),
    .ctrl_col_mask       (col_mask)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mk_cmd(input logic [9:0] a, b, c, d,
                                         input logic [7:0] k, n, m);
    return {d, c, b, a, n, k, m};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Walks cycles 1..ncyc after acceptance and checks every read/valid strobe.
  task automatic stream_check(input int ncyc, input logic [9:0] a, b, c, input int m,
                              input bit inject);
    logic [9:0] e;
    for (int cyc = 1; cyc <= ncyc; cyc++) begin
      if (inject && cyc == 5) begin
        cmd_valid = 1'b1;
        cmd_data  = mk_cmd(10'h055, 10'h066, 10'h077, 10'h088, 8'd1, 8'd1, 8'd1);
      end else begin
        cmd_valid = 1'b0;
      end
      tick();
      chk("busy", 64'(busy), 64'(1));
      chk("cmd_ready", 64'(cmd_ready), 64'(0));
      chk("done_irq_run", 64'(done_irq), 64'(0));
      chk("rd_en_b", 64'(rd_en_b), 64'(cyc >= 1 && cyc <= 16));
      if (cyc >= 1 && cyc <= 16) begin
        e = b + 10'(cyc - 1);
        chk("rd_addr_b", 64'(rd_addr_b), 64'(e));
      end
      chk("b_accept_w", 64'(b_accept_w), 64'(cyc >= 2 && cyc <= 17));
      if (cyc >= 2 && cyc <= 17) chk("b_weight_index", 64'(b_weight_index), 64'(cyc - 2));
      chk("rd_en_a", 64'(rd_en_a), 64'(cyc >= 18 && cyc <= 17 + m));
      if (cyc >= 18 && cyc <= 17 + m) begin
        e = a + 10'(cyc - 18);
        chk("rd_addr_a", 64'(rd_addr_a), 64'(e));
      end
      chk("a_valid", 64'(a_valid), 64'(cyc >= 19 && cyc <= 18 + m));
      chk("psum_valid", 64'(psum_valid), 64'(cyc >= 19 && cyc <= 18 + m));
      chk("a_switch", 64'(a_switch), 64'(cyc == 19));
      chk("rd_en_c", 64'(rd_en_c), 64'(cyc >= 50 && cyc <= 49 + m));
      if (cyc >= 50 && cyc <= 49 + m) begin
        e = c + 10'(cyc - 50);
        chk("rd_addr_c", 64'(rd_addr_c), 64'(e));
      end
      chk("c_valid", 64'(c_valid), 64'(cyc >= 51 && cyc <= 50 + m));
      chk("vpu_mode", 64'(vpu_mode), 64'(1));
    end
  endtask

  // n writeback pulses with random gaps; D address checked in each pulse cycle.
  task automatic writebacks(input int n, input logic [9:0] d);
    logic [9:0] e;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) begin
        tick();
        chk("done_irq_gap", 64'(done_irq), 64'(0));
      end
      wb_valid = 1'b1;
      e = d + 10'(i);
      chk("wr_addr_d", 64'(wr_addr_d), 64'(e));
      tick();
      wb_valid = 1'b0;
      chk("done_irq_wb", 64'(done_irq), 64'(i == n - 1));
      chk("busy_wb", 64'(busy), 64'(i != n - 1));
      chk("cmd_ready_wb", 64'(cmd_ready), 64'(i == n - 1));
    end
    tick();
    chk("done_irq_one_shot", 64'(done_irq), 64'(0));
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_data  = '0;
    wb_valid  = 1'b0;
    repeat (10) tick();

    // Reset state
    chk("rst_cmd_ready", 64'(cmd_ready), 64'(1));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done_irq), 64'(0));
    chk("rst_enables", 64'({rd_en_a, rd_en_b, rd_en_c, a_valid, a_switch, psum_valid,
                            b_accept_w, c_valid}), 64'(0));
    chk("rst_masks", {32'h0, row_mask, col_mask}, 64'(0));
    chk("rst_vpu_mode", 64'(vpu_mode), 64'(0));
    rst = 1'b0;
    tick();

    // Main command, with an ignored command injected while busy
    cmd_valid = 1'b1;
    cmd_data  = mk_cmd(10'h100, 10'h200, 10'h300, 10'h000, 8'd8, 8'd8, 8'd16);
    tick();
    cmd_valid = 1'b0;
    chk("cmd_ready_accept", 64'(cmd_ready), 64'(0));
    chk("row_mask_k8", 64'(row_mask), 64'(16'h00FF));
    chk("col_mask_n8", 64'(col_mask), 64'(16'h00FF));
    stream_check(70, 10'h100, 10'h200, 10'h300, 16, 1'b1);
    chk("row_mask_held", 64'(row_mask), 64'(16'h00FF));
    writebacks(16, 10'h000);

    // Writeback in IDLE is ignored
    wb_valid = 1'b1;
    tick();
    wb_valid = 1'b0;
    chk("idle_wb_done", 64'(done_irq), 64'(0));
    chk("idle_wb_busy", 64'(busy), 64'(0));

    // K=20, N=3 clamping, then reset during STREAM
    cmd_valid = 1'b1;
    cmd_data  = mk_cmd(10'h010, 10'h020, 10'h030, 10'h040, 8'd20, 8'd3, 8'd4);
    tick();
    cmd_valid = 1'b0;
    chk("row_mask_k20", 64'(row_mask), 64'(16'hFFFF));
    chk("col_mask_n3", 64'(col_mask), 64'(16'h0007));
    repeat (19) tick();
    chk("pre_rst_rd_en_a", 64'(rd_en_a), 64'(1));
    rst = 1'b1;
    tick();
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_cmd_ready", 64'(cmd_ready), 64'(1));
    chk("midrst_done", 64'(done_irq), 64'(0));
    chk("midrst_enables", 64'({rd_en_a, rd_en_b, rd_en_c, a_valid, a_switch, psum_valid,
                               b_accept_w, c_valid}), 64'(0));
    chk("midrst_masks", {32'h0, row_mask, col_mask}, 64'(0));
    chk("midrst_vpu_mode", 64'(vpu_mode), 64'(0));

    // M=0 accepted on the first cycle after reset falls
    rst       = 1'b0;
    cmd_valid = 1'b1;
    cmd_data  = mk_cmd(10'h111, 10'h222, 10'h333, 10'h044, 8'd3, 8'd16, 8'd0);
    tick();
    cmd_valid = 1'b0;
    chk("m0_done", 64'(done_irq), 64'(1));
    chk("m0_cmd_ready", 64'(cmd_ready), 64'(1));
    chk("m0_busy", 64'(busy), 64'(0));
    chk("m0_row_mask", 64'(row_mask), 64'(16'h0007));
    chk("m0_col_mask", 64'(col_mask), 64'(16'hFFFF));
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("m0_no_reads", 64'({rd_en_a, rd_en_b, rd_en_c}), 64'(0));
      chk("m0_done_one_shot", 64'(done_irq), 64'(0));
    end

    // Normal completion after the abort, with address wraparound
    cmd_valid = 1'b1;
    cmd_data  = mk_cmd(10'h3FF, 10'h3F8, 10'h3FE, 10'h3FF, 8'd16, 8'd16, 8'd2);
    tick();
    cmd_valid = 1'b0;
    chk("wrap_row_mask", 64'(row_mask), 64'(16'hFFFF));
    stream_check(55, 10'h3FF, 10'h3F8, 10'h3FE, 2, 1'b0);
    writebacks(2, 10'h3FF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tpu_control_unit.md
# tpu_control_unit

Command sequencer for the 16×16 weight-stationary TPU tile. Accepts one 64-bit GEMM command from the host, then drives the read/valid strobes of the core's B (weight), A (input), C (bias) streams and the D writeback address. It raises `done_irq` once the core has written back every output row. It sits between the host command port and `tpu_core`; it holds no datapath.

## Interface
- `ADDR_WIDTH`, 10: unified-buffer address width. The command packing requires 4·ADDR_WIDTH+24 ≤ 64.
- `SYSTOLIC_ARRAY_WIDTH` (W), 16: array dimension.
- `C_DELAY`, 2·W: cycles from an A-row read to the matching C-row read.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command strobe.
- `cmd_data`  in  64  command: [7:0] len_m, [15:8] len_k, [23:16] len_n, then ADDR_WIDTH-bit fields upward: addr_a, addr_b, addr_c, addr_d (addr_d at MSBs).
- `cmd_ready`  out  1  high when IDLE.
- `busy`  out  1  high when not IDLE.
- `done_irq`  out  1  one-cycle completion pulse.
- `ctrl_rd_addr_a` / `ctrl_rd_en_a`  out  ADDR_WIDTH / 1  A-row read.
- `ctrl_a_valid`, `ctrl_a_switch`, `ctrl_psum_valid`  out  1 each  A data valid, weight-bank switch, psum-input valid.
- `ctrl_rd_addr_b` / `ctrl_rd_en_b`  out  ADDR_WIDTH / 1  B-row read.
- `ctrl_b_accept_w`  out  1  latch the B row into the array.
- `ctrl_b_weight_index`  out  $clog2(W)  target array row.
- `ctrl_rd_addr_c` / `ctrl_rd_en_c`  out  ADDR_WIDTH / 1  bias-row read.
- `ctrl_c_valid`  out  1  bias data valid.
- `ctrl_vpu_mode`  out  3  3'd1 (bias add) while busy, 0 otherwise.
- `core_writeback_valid`  in  1  core writes one output row this cycle.
- `ctrl_wr_addr_d`  out  ADDR_WIDTH  D row address, combinational.
- `ctrl_row_mask`, `ctrl_col_mask`  out  W each  active K rows / N columns.

## Operation
- **States:** IDLE → LOAD_B → STREAM → WAIT_WB → IDLE.
- **IDLE:** `cmd_valid` is sampled only in IDLE. On acceptance, latch all fields and leave IDLE.
  - `cmd_valid` while busy is ignored; nothing is queued.
- **Length handling:**
  - len_k and len_n are clamped to W.
  - Masks: `ctrl_row_mask[i]` = (i < len_k); `ctrl_col_mask[j]` = (j < len_n). Both are registered at acceptance and held until the next command.
  - len_k = 0 or len_n = 0 gives an all-zero mask; the run still proceeds.
  - len_m = 0: go directly to IDLE with a `done_irq` pulse, no memory accesses.
- **LOAD_B:** always issue W reads, addr_b+i for i = 0..W−1, on consecutive cycles. Rows beyond len_k are still loaded; masks disable them.
- **STREAM:**
  - Issue len_m consecutive A reads, addr_a+m.
  - Bias reads: addr_c+m, one per A row, each issued C_DELAY cycles after the corresponding A read.
  - Stay in STREAM until the last C read has issued.
- **WAIT_WB:**
  - `wb_row_cnt` counts `core_writeback_valid` pulses in any non-IDLE state.
  - `ctrl_wr_addr_d` = addr_d + `wb_row_cnt` (combinational, valid in the pulse cycle).
  - When the count reaches len_m: return to IDLE and pulse `done_irq`. `cmd_ready` rises in the same cycle.
  - `core_writeback_valid` in IDLE is ignored.
- **Addresses:** all address sums wrap modulo 2^ADDR_WIDTH.

## Timing
Cycle 0 = the edge at which the command is accepted.
- **B load:**
  - `ctrl_rd_en_b` high on cycles 1..W.
  - `ctrl_b_accept_w` high on cycles 2..W+1, carrying `ctrl_b_weight_index` = i (one-cycle buffer read latency).
- **A stream:**
  - `ctrl_rd_en_a` high on cycles W+2 .. W+1+len_m.
  - `ctrl_a_valid` and `ctrl_psum_valid` high on cycles W+3 .. W+2+len_m.
  - `ctrl_a_switch` pulses only on cycle W+3.
- **C stream:** `ctrl_rd_en_c` for row m on cycle W+2+m+C_DELAY; `ctrl_c_valid` one cycle later.
- **Completion:** `done_irq` is registered, high for exactly one cycle after the edge sampling the len_m-th writeback.
- **Registered outputs:** all outputs except `cmd_ready` and `ctrl_wr_addr_d`.
- **Reset:**
  - All outputs and counters go to 0; `cmd_ready` = 1 because state = IDLE.
  - A reset mid-command aborts it with no `done_irq`. A new command can be accepted on the first cycle after `rst` falls.

## Test plan
- **Reset:** hold `rst` 10 cycles → `cmd_ready`=1, `busy`=0, every enable/valid/mask/`done_irq` = 0.
- **Decode + B load:** command A=0x100, B=0x200, C=0x300, D=0x000, K=8, N=8, M=16.
  - Masks = 16'h00FF.
  - `ctrl_rd_en_b` addresses 0x200..0x20F on cycles 1..16.
  - `ctrl_b_accept_w` indices 0..15 on cycles 2..17.
- **A/C streams (same command):**
  - A reads 0x100..0x10F on cycles 18..33; `ctrl_a_valid` on cycles 19..34; single `ctrl_a_switch` on cycle 19.
  - C reads 0x300..0x30F starting cycle 50 (C_DELAY=32).
- **Writeback:** 16 `core_writeback_valid` pulses with random gaps.
  - Each pulse sees `ctrl_wr_addr_d` = 0x000+n.
  - `done_irq` pulses once after the 16th; `busy` falls, `cmd_ready` rises.
- **Edge commands:**
  - `cmd_valid` while busy → ignored.
  - K=20, N=3 → row_mask FFFF, col_mask 0007.
  - M=0 → `done_irq` next cycle, no read enables.
- **Mid-run reset:** assert `rst` during STREAM → all outputs 0 next cycle, no `done_irq`; a new command is accepted afterwards and completes normally.
